dram_cmd_scheduler: RTL and testbench

//  Takes one decoded memory request at a time from the request queue (read, write, ifetch).

---
 rtl/dram_cmd_scheduler.sv | 161 ++++++++++++++++
 tb/tb_dram_cmd_scheduler.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/dram_cmd_scheduler.sv
// rtl/dram_cmd_scheduler.sv - open-page DRAM command sequencer (PRE/ACT/RD/WR) for one request at a time
module dram_cmd_scheduler #(
    parameter int ADDRESS_WIDTH     = 33,
    parameter int BANK_LSB          = 6,
    parameter int ROW_LSB           = 18,
    parameter int ROW_BITS          = 15,
    parameter int T_RP              = 24,
    parameter int T_RCD             = 24,
    parameter int T_RAS             = 52,
    parameter int T_CL              = 24,
    parameter int T_BURST           = 4,
    parameter bit REPORT_ILLEGAL_OP = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [ADDRESS_WIDTH-1:0] req_addr,
    output logic                     cmd_valid,
    output logic [2:0]               cmd_type,
    output logic [1:0]               cmd_bank,
    output logic [ADDRESS_WIDTH-1:0] cmd_addr,
    output logic                     done,
    output logic                     busy
);

    if (T_RP > 255 || T_RCD > 255 || T_RAS > 255 || T_CL > 255 || T_BURST > 255 ||
        T_CL + T_BURST - 1 > 255) begin : g_param_check
        $fatal(1, "dram_cmd_scheduler: timing parameter exceeds 8-bit counter range");
    end

    localparam logic [7:0] LD_RP   = 8'(T_RP - 1);
    localparam logic [7:0] LD_RCD  = 8'(T_RCD - 1);
    localparam logic [7:0] LD_RAS  = 8'(T_RAS - 1);
    localparam logic [7:0] LD_DATA = 8'(T_CL + T_BURST - 1);

    localparam logic [2:0] CMD_NOP = 3'd0;
    localparam logic [2:0] CMD_ACT = 3'd1;
    localparam logic [2:0] CMD_RD  = 3'd2;
    localparam logic [2:0] CMD_WR  = 3'd3;
    localparam logic [2:0] CMD_PRE = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_PRE, S_WAIT_RP, S_ACT, S_WAIT_RCD, S_ISSUE, S_WAIT_DATA
    } state_t;

    state_t                     state, state_next;
    logic [1:0]                 op_q;
    logic [ADDRESS_WIDTH-1:0]   addr_q;
    logic [1:0]                 bank_q;
    logic [ROW_BITS-1:0]        row_q;
    logic [7:0]                 cnt;
    logic [3:0]                 bank_open;
    logic [ROW_BITS-1:0]        open_row [4];
    logic [7:0]                 ras_cnt  [4];

    logic accept;
    logic pre_fire;

    assign accept   = req_valid && req_ready;
    assign pre_fire = (state == S_PRE) && (ras_cnt[bank_q] == 8'd0);

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:      if (accept && req_op != 2'd3) state_next = S_CHECK;
            S_CHECK: begin
                if (!bank_open[bank_q])               state_next = S_ACT;
                else if (open_row[bank_q] == row_q)   state_next = S_ISSUE;
                else                                  state_next = S_PRE;
            end
            S_PRE:       if (pre_fire) state_next = S_WAIT_RP;
            S_WAIT_RP:   if (cnt <= 8'd1) state_next = S_ACT;
            S_ACT:       state_next = S_WAIT_RCD;
            S_WAIT_RCD:  if (cnt <= 8'd1) state_next = S_ISSUE;
            S_ISSUE:     state_next = S_WAIT_DATA;
            S_WAIT_DATA: if (cnt == 8'd0) state_next = S_IDLE;
            default:     state_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = rst_n && (state == S_IDLE);
        cmd_valid = 1'b0;
        cmd_type  = CMD_NOP;
        done      = (state == S_WAIT_DATA) && (cnt == 8'd0);
        busy      = (state != S_IDLE);
        case (state)
            S_PRE: if (pre_fire) begin
                cmd_valid = 1'b1;
                cmd_type  = CMD_PRE;
            end
            S_ACT: begin
                cmd_valid = 1'b1;
                cmd_type  = CMD_ACT;
            end
            S_ISSUE: begin
                cmd_valid = 1'b1;
                cmd_type  = (op_q == 2'd1) ? CMD_WR : CMD_RD;
            end
            default: ;
        endcase
    end

    assign cmd_bank = bank_q;
    assign cmd_addr = addr_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q      <= '0;
            addr_q    <= '0;
            bank_q    <= '0;
            row_q     <= '0;
            cnt       <= '0;
            bank_open <= '0;
        end else begin
            if (accept && req_op != 2'd3) begin
                op_q   <= req_op;
                addr_q <= req_addr;
                bank_q <= req_addr[BANK_LSB +: 2];
                row_q  <= req_addr[ROW_LSB +: ROW_BITS];
            end
            // One shared countdown serves tRP, tRCD and the data window; only one is live at a time.
            if (pre_fire) begin
                cnt                <= LD_RP;
                bank_open[bank_q]  <= 1'b0;
            end else if (state == S_ACT) begin
                cnt                <= LD_RCD;
                bank_open[bank_q]  <= 1'b1;
            end else if (state == S_ISSUE) begin
                cnt <= LD_DATA;
            end else if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && state == S_ACT) open_row[bank_q] <= row_q;
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (!rst_n)                                     ras_cnt[b] <= 8'd0;
            else if (state == S_ACT && bank_q == 2'(b))     ras_cnt[b] <= LD_RAS;
            else if (ras_cnt[b] != 8'd0)                    ras_cnt[b] <= ras_cnt[b] - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (REPORT_ILLEGAL_OP && rst_n && accept && req_op == 2'd3)
            $error("dram_cmd_scheduler: illegal req_op 3 dropped, addr=%h", req_addr);
    end

endmodule

// File: tb/tb_dram_cmd_scheduler.sv
// tb/tb_dram_cmd_scheduler.sv - directed self-checking bench for dram_cmd_scheduler
module tb_dram_cmd_scheduler;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_op = 2'd0;
    logic [32:0] req_addr = '0;
    logic        cmd_valid;
    logic [2:0]  cmd_type;
    logic [1:0]  cmd_bank;
    logic [32:0] cmd_addr;
    logic        done;
    logic        busy;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int acc, pre_c, act_c, rw_c, done_c, n_cmd;
    int rw_type, rw_bank, act_bank, pre_bank;
    logic [32:0] rw_addr;

    // T_RAS is stretched so a row conflict right after an ACT visibly stalls the PRE.
    dram_cmd_scheduler #(.T_RAS(80), .REPORT_ILLEGAL_OP(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_bank(cmd_bank), .cmd_addr(cmd_addr),
        .done(done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic run_req(input logic [1:0] op, input logic [32:0] addr, input int limit);
        acc = -1; pre_c = -1; act_c = -1; rw_c = -1; done_c = -1; n_cmd = 0;
        rw_type = -1; rw_bank = -1; act_bank = -1; pre_bank = -1; rw_addr = '0;
        req_op = op; req_addr = addr; req_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (req_ready) begin acc = cyc; break; end
            @(negedge clk);
        end
        checks++;
        if (acc < 0) begin
            errors++; $display("FAIL accept_timeout got no req_ready want ready within 100 cycles");
        end
        @(negedge clk);
        req_valid = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (cmd_valid) begin
                n_cmd++;
                case (cmd_type)
                    3'd1: begin act_c = cyc; act_bank = cmd_bank; end
                    3'd4: begin pre_c = cyc; pre_bank = cmd_bank; end
                    3'd2, 3'd3: begin rw_c = cyc; rw_type = cmd_type; rw_bank = cmd_bank; rw_addr = cmd_addr; end
                    default: ;
                endcase
            end
            if (done) begin done_c = cyc; break; end
            @(negedge clk);
        end
        checks++;
        if (done_c < 0) begin
            errors++; $display("FAIL done_timeout got no done want done within %0d cycles", limit);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (cmd_valid !== 1'b0) begin errors++; $display("FAIL rst_cmd_valid got %b want 0", cmd_valid); end
        checks++; if (cmd_type !== 3'd0) begin errors++; $display("FAIL rst_cmd_type got %0d want 0", cmd_type); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b want 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %b want 0", req_ready); end
        checks++; if (cmd_addr !== 33'd0 || cmd_bank !== 2'd0) begin
            errors++; $display("FAIL rst_cmd_addr got %h/%0d want 0/0", cmd_addr, cmd_bank);
        end
        req_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_req_ready got %b want 1", req_ready); end
    endtask

    task automatic test_miss_read();
        run_req(2'd0, 33'h0_0004_0040, 200);
        checks++; if (act_c !== acc + 2) begin errors++; $display("FAIL miss_act_cycle got %0d want %0d", act_c, acc + 2); end
        checks++; if (act_bank !== 1) begin errors++; $display("FAIL miss_act_bank got %0d want 1", act_bank); end
        checks++; if (rw_c !== acc + 26 || rw_type !== 2) begin
            errors++; $display("FAIL miss_rd got cyc %0d type %0d want cyc %0d type 2", rw_c, rw_type, acc + 26);
        end
        checks++; if (rw_addr !== 33'h0_0004_0040) begin errors++; $display("FAIL miss_rd_addr got %h want 000040040", rw_addr); end
        checks++; if (done_c !== acc + 54) begin errors++; $display("FAIL miss_done got %0d want %0d", done_c, acc + 54); end
        checks++; if (pre_c !== -1 || n_cmd !== 2) begin
            errors++; $display("FAIL miss_cmd_count got pre %0d n %0d want pre -1 n 2", pre_c, n_cmd);
        end
    endtask

    task automatic test_hit_read();
        run_req(2'd2, 33'h0_0004_0048, 100);
        checks++; if (rw_c !== acc + 2 || rw_type !== 2) begin
            errors++; $display("FAIL hit_rd got cyc %0d type %0d want cyc %0d type 2", rw_c, rw_type, acc + 2);
        end
        checks++; if (act_c !== -1 || n_cmd !== 1) begin
            errors++; $display("FAIL hit_no_act got act %0d n %0d want act -1 n 1", act_c, n_cmd);
        end
        checks++; if (done_c !== acc + 30) begin errors++; $display("FAIL hit_done got %0d want %0d", done_c, acc + 30); end
    endtask

    task automatic test_write_other_bank();
        run_req(2'd1, 33'h0_0004_0080, 200);
        checks++; if (act_c !== acc + 2 || act_bank !== 2) begin
            errors++; $display("FAIL wr_act got cyc %0d bank %0d want cyc %0d bank 2", act_c, act_bank, acc + 2);
        end
        checks++; if (rw_c !== acc + 26 || rw_type !== 3 || rw_bank !== 2) begin
            errors++; $display("FAIL wr_cmd got cyc %0d type %0d bank %0d want cyc %0d type 3 bank 2", rw_c, rw_type, rw_bank, acc + 26);
        end
        checks++; if (done_c !== acc + 54) begin errors++; $display("FAIL wr_done got %0d want %0d", done_c, acc + 54); end
        run_req(2'd0, 33'h0_0004_0040, 100);
        checks++; if (act_c !== -1 || rw_c !== acc + 2 || rw_bank !== 1) begin
            errors++; $display("FAIL bank1_kept got act %0d rd %0d bank %0d want act -1 rd %0d bank 1", act_c, rw_c, rw_bank, acc + 2);
        end
    endtask

    task automatic test_conflict();
        int first_act;
        do_reset();
        run_req(2'd0, 33'h0_0004_0040, 200);
        first_act = act_c;
        run_req(2'd0, 33'h0_0008_0040, 400);
        checks++; if (pre_c !== first_act + 80 || pre_bank !== 1) begin
            errors++; $display("FAIL conf_pre got cyc %0d bank %0d want cyc %0d bank 1", pre_c, pre_bank, first_act + 80);
        end
        checks++; if (act_c !== pre_c + 24) begin errors++; $display("FAIL conf_act got %0d want %0d", act_c, pre_c + 24); end
        checks++; if (rw_c !== act_c + 24 || rw_type !== 2) begin
            errors++; $display("FAIL conf_rd got cyc %0d type %0d want cyc %0d type 2", rw_c, rw_type, act_c + 24);
        end
        checks++; if (done_c !== rw_c + 28) begin errors++; $display("FAIL conf_done got %0d want %0d", done_c, rw_c + 28); end
        run_req(2'd0, 33'h0_0008_0044, 100);
        checks++; if (act_c !== -1 || rw_c !== acc + 2) begin
            errors++; $display("FAIL conf_new_row_open got act %0d rd %0d want act -1 rd %0d", act_c, rw_c, acc + 2);
        end
    endtask

    task automatic test_illegal_op();
        int bad = 0;
        req_op = 2'd3; req_addr = 33'h0_0004_0040; req_valid = 1'b1;
        for (int k = 0; k < 40; k++) begin
            if (cmd_valid || done || busy || !req_ready) bad++;
            @(negedge clk);
        end
        req_valid = 1'b0; req_op = 2'd0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL illegal_op got %0d bad cycles want 0", bad); end
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        int a0 = -1;
        req_op = 2'd0; req_addr = 33'h0_0004_0000; req_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (req_ready) begin a0 = cyc; break; end
            @(negedge clk);
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1 || a0 < 0) begin errors++; $display("FAIL mid_busy got %b want 1", busy); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0 || cmd_valid !== 1'b0) begin
            errors++; $display("FAIL mid_reset_idle got busy %b cmd %b want 0 0", busy, cmd_valid);
        end
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (done || cmd_valid || busy) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL mid_no_done got %0d bad cycles want 0", bad); end
        run_req(2'd0, 33'h0_0004_0000, 200);
        checks++; if (act_c !== acc + 2 || rw_c !== acc + 26) begin
            errors++; $display("FAIL mid_restart got act %0d rd %0d want act %0d rd %0d", act_c, rw_c, acc + 2, acc + 26);
        end
    endtask

    initial begin
        test_reset();
        test_miss_read();
        test_hit_read();
        test_write_other_bank();
        test_conflict();
        test_illegal_op();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
